// File: rtl/video_chk_pkg.sv
// Shared constants, error-bit indices and the CRC step for the video frame checker.
package video_chk_pkg;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // Bit positions inside the 4-bit frame error vector.
    typedef enum logic [1:0] {
        ERR_HTOT = 2'd0,
        ERR_HACT = 2'd1,
        ERR_VTOT = 2'd2,
        ERR_VACT = 2'd3
    } err_idx_e;

    // One CRC-16-CCITT update over a 24-bit word, MSB first ({r,g,b}).
    function automatic logic [15:0] crc16_step24(input logic [15:0] crc,
                                                 input logic [23:0] data24);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ data24[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC16_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/video_chk_line_meter.sv
// Input register stage, sync leading-edge detection and per-line length / DE counting.
// All outputs are registered one stage behind the input register so that
// strobes and pixel data stay aligned with each other.
module video_chk_line_meter #(
    parameter int CW        = 12,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    input  logic [7:0]    r,
    input  logic [7:0]    g,
    input  logic [7:0]    b,
    output logic          line_stb,
    output logic [CW-1:0] line_len,
    output logic [CW-1:0] line_de,
    output logic          frame_stb,
    output logic          pix_de,
    output logic [23:0]   pix_rgb
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          hs_s1_reg;
    logic          vs_s1_reg;
    logic          hs_prev_reg;
    logic          vs_prev_reg;
    logic          de_s1_reg;
    logic [23:0]   rgb_s1_reg;
    logic [CW-1:0] h_cnt_reg;
    logic [CW-1:0] de_cnt_reg;
    logic [CW-1:0] h_cnt_next;
    logic [CW-1:0] de_cnt_next;
    logic [CW-1:0] len_next;
    logic          hs_edge;
    logic          vs_edge;

    // Register every video input once; keep the previous sync samples for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_reg   <= ~HSYNC_POL;
            vs_s1_reg   <= ~VSYNC_POL;
            hs_prev_reg <= ~HSYNC_POL;
            vs_prev_reg <= ~VSYNC_POL;
            de_s1_reg   <= 1'b0;
            rgb_s1_reg  <= '0;
        end else begin
            hs_s1_reg   <= hsync;
            vs_s1_reg   <= vsync;
            hs_prev_reg <= hs_s1_reg;
            vs_prev_reg <= vs_s1_reg;
            de_s1_reg   <= de;
            rgb_s1_reg  <= {r, g, b};
        end
    end

    assign hs_edge = (hs_s1_reg == HSYNC_POL) && (hs_prev_reg != HSYNC_POL);
    assign vs_edge = (vs_s1_reg == VSYNC_POL) && (vs_prev_reg != VSYNC_POL);

    // Saturating line-length and DE counters; a DE on the edge cycle starts the new line.
    always_comb begin
        h_cnt_next  = h_cnt_reg;
        de_cnt_next = de_cnt_reg;
        len_next    = (h_cnt_reg == CNT_MAX) ? CNT_MAX : h_cnt_reg + 1'b1;
        if (hs_edge) begin
            h_cnt_next  = '0;
            de_cnt_next = de_s1_reg ? CW'(1) : '0;
        end else begin
            if (h_cnt_reg != CNT_MAX) begin
                h_cnt_next = h_cnt_reg + 1'b1;
            end
            if (de_s1_reg && (de_cnt_reg != CNT_MAX)) begin
                de_cnt_next = de_cnt_reg + 1'b1;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg  <= '0;
            de_cnt_reg <= '0;
        end else begin
            h_cnt_reg  <= h_cnt_next;
            de_cnt_reg <= de_cnt_next;
        end
    end

    // Second stage: line results, strobes and the aligned pixel stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_stb  <= 1'b0;
            line_len  <= '0;
            line_de   <= '0;
            frame_stb <= 1'b0;
            pix_de    <= 1'b0;
            pix_rgb   <= '0;
        end else begin
            line_stb  <= hs_edge;
            frame_stb <= vs_edge;
            pix_de    <= de_s1_reg;
            pix_rgb   <= rgb_s1_reg;
            if (hs_edge) begin
                line_len <= len_next;
                line_de  <= de_cnt_reg;
            end
        end
    end

endmodule

// File: rtl/video_frame_checker.sv
// Per-frame timing / CRC checker for the video output bus.
// Line closes are folded into the frame accumulators before a coincident
// frame close so a line ending on the vsync edge still belongs to the old frame.
module video_frame_checker
    import video_chk_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int H_TOTAL   = 1650,
    parameter int V_ACTIVE  = 720,
    parameter int V_TOTAL   = 750,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CW        = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic [7:0]    i_r,
    input  logic [7:0]    i_g,
    input  logic [7:0]    i_b,
    output logic          o_frame_valid,
    output logic [CW-1:0] o_h_total,
    output logic [CW-1:0] o_v_total,
    output logic [CW-1:0] o_v_active,
    output logic [15:0]   o_crc,
    output logic [3:0]    o_err,
    output logic          o_locked,
    output logic [15:0]   o_frame_cnt
);

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
    localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);

    logic          line_stb;
    logic [CW-1:0] line_len;
    logic [CW-1:0] line_de;
    logic          frame_stb;
    logic          pix_de;
    logic [23:0]   pix_rgb;

    logic          started_reg;
    logic          have_line_reg;
    logic [CW-1:0] line_cnt_reg;
    logic [CW-1:0] act_lines_reg;
    logic [1:0]    err_line_reg;
    logic [CW-1:0] last_len_reg;
    logic [15:0]   crc_reg;

    logic [CW-1:0] line_cnt_next;
    logic [CW-1:0] act_lines_next;
    logic [1:0]    err_line_next;
    logic [CW-1:0] last_len_next;
    logic [3:0]    frame_err;
    logic [15:0]   crc_next;
    logic [15:0]   crc_start;

    video_chk_line_meter #(
        .CW        (CW),
        .HSYNC_POL (HSYNC_POL),
        .VSYNC_POL (VSYNC_POL)
    ) u_line_meter (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .hsync     (i_hsync),
        .vsync     (i_vsync),
        .de        (i_de),
        .r         (i_r),
        .g         (i_g),
        .b         (i_b),
        .line_stb  (line_stb),
        .line_len  (line_len),
        .line_de   (line_de),
        .frame_stb (frame_stb),
        .pix_de    (pix_de),
        .pix_rgb   (pix_rgb)
    );

    // Fold a closing line into the running frame totals (only once a full line exists).
    always_comb begin
        line_cnt_next  = line_cnt_reg;
        act_lines_next = act_lines_reg;
        err_line_next  = err_line_reg;
        last_len_next  = last_len_reg;
        if (line_stb) begin
            last_len_next = line_len;
            if (line_cnt_reg != CNT_MAX) begin
                line_cnt_next = line_cnt_reg + 1'b1;
            end
            if (have_line_reg) begin
                if (line_len != H_TOTAL_C) begin
                    err_line_next[0] = 1'b1;
                end
                if (line_de != '0) begin
                    if (act_lines_reg != CNT_MAX) begin
                        act_lines_next = act_lines_reg + 1'b1;
                    end
                    if (line_de != H_ACTIVE_C) begin
                        err_line_next[1] = 1'b1;
                    end
                end
            end
        end
    end

    // Frame-level error vector as it would be reported by a close this cycle.
    always_comb begin
        frame_err           = '0;
        frame_err[ERR_HTOT] = err_line_next[0];
        frame_err[ERR_HACT] = err_line_next[1];
        frame_err[ERR_VTOT] = (line_cnt_next != V_TOTAL_C);
        frame_err[ERR_VACT] = (act_lines_next != V_ACTIVE_C);
    end

    // CRC continuation and the restart value used when a new frame begins.
    always_comb begin
        crc_next  = pix_de ? crc16_step24(crc_reg, pix_rgb) : crc_reg;
        crc_start = pix_de ? crc16_step24(CRC16_INIT, pix_rgb) : CRC16_INIT;
    end

    // Per-frame accumulators; a vsync edge restarts them, and a coincident hsync opens line 0.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            started_reg   <= 1'b0;
            have_line_reg <= 1'b0;
            line_cnt_reg  <= '0;
            act_lines_reg <= '0;
            err_line_reg  <= '0;
            last_len_reg  <= '0;
            crc_reg       <= CRC16_INIT;
        end else if (frame_stb) begin
            started_reg   <= 1'b1;
            have_line_reg <= line_stb;
            line_cnt_reg  <= '0;
            act_lines_reg <= '0;
            err_line_reg  <= '0;
            last_len_reg  <= last_len_next;
            crc_reg       <= crc_start;
        end else begin
            have_line_reg <= have_line_reg | line_stb;
            line_cnt_reg  <= line_cnt_next;
            act_lines_reg <= act_lines_next;
            err_line_reg  <= err_line_next;
            last_len_reg  <= last_len_next;
            crc_reg       <= crc_next;
        end
    end

    // Summary outputs: latched on every frame close except the very first vsync after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_frame_valid <= 1'b0;
            o_h_total     <= '0;
            o_v_total     <= '0;
            o_v_active    <= '0;
            o_crc         <= '0;
            o_err         <= '0;
            o_locked      <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_frame_valid <= 1'b0;
            if (frame_stb && started_reg) begin
                o_frame_valid <= 1'b1;
                o_h_total     <= last_len_next;
                o_v_total     <= line_cnt_next;
                o_v_active    <= act_lines_next;
                o_crc         <= crc_reg;
                o_err         <= frame_err;
                o_locked      <= (frame_err == 4'b0000);
                o_frame_cnt   <= o_frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/video_frame_checker.md
Name: video_frame_checker

Overview:
- Downstream consumer of the top-level video output bus: hsync, vsync, DE and 8-bit R/G/B.
- Measures per-frame timing (h_total, v_total, active pixels per line, active lines) against parameterised expectations.
- Computes a CRC-16 over active pixels and reports a frame summary with error flags.
- Instantiated beside aars_video_top in the simulation top, and optionally on-chip driving debug LEDs. Video is synchronous to sys_clk; the ADV pixel clock output is not an input.

Parameters:
- H_ACTIVE, 1280, expected DE cycles per active line
- H_TOTAL, 1650, expected sys_clk cycles between hsync leading edges
- V_ACTIVE, 720, expected lines containing DE per frame
- V_TOTAL, 750, expected hsync leading edges between vsync leading edges
- HSYNC_POL, 1, asserted level of hsync (1 = active-high)
- VSYNC_POL, 1, asserted level of vsync
- CW, 12, width of all timing counters

Ports:
- sys_clk  in  1  clock; video inputs are synchronous to it
- sys_rst_n  in  1  asynchronous active-low reset
- i_hsync  in  1  horizontal sync
- i_vsync  in  1  vertical sync
- i_de  in  1  data enable
- i_r / i_g / i_b  in  8 each  pixel colour
- o_frame_valid  out  1  one-cycle pulse: summary outputs updated
- o_h_total  out  CW  last measured line length
- o_v_total  out  CW  measured lines in last frame
- o_v_active  out  CW  measured active lines in last frame
- o_crc  out  16  CRC of last frame's active pixels
- o_err  out  4  [0] h_total mismatch, [1] h_active mismatch, [2] v_total mismatch, [3] v_active mismatch
- o_locked  out  1  last completed frame had o_err == 0
- o_frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0

Behaviour:
- All outputs reset to 0.
- Reset is asynchronous assert; all internal state clears. After reset, nothing is checked until the first vsync leading edge.

Input and edge detection:
- All inputs are registered once (stage S1).
- Leading edge = S1 value at asserted polarity while the previous S1 value was deasserted.

Horizontal measurement:
- h_cnt increments every cycle and saturates at 2^CW-1.
- On an hsync edge: line_len = h_cnt+1, then h_cnt <= 0. de_cnt is latched and cleared.
- de_cnt counts S1 DE cycles and saturates.
- Lines are checked only if a previous hsync edge exists since frame start:
  - line_len != H_TOTAL sets frame err[0].
  - A line with de_cnt != 0 increments act_lines; if de_cnt != H_ACTIVE, it sets err[1].
  - A line with de_cnt == 0 is not an active line.
- Each hsync edge increments line_cnt.

CRC:
- CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB-first.
- Each DE cycle processes the 24-bit word {r,g,b} in one step.
- Reinitialised at every vsync edge.

Frame close (on a vsync edge):
- First vsync edge after reset: start the frame only; no summary output.
- Later edges:
  - err[2] = line_cnt != V_TOTAL.
  - err[3] = act_lines != V_ACTIVE.
  - Latch o_v_total = line_cnt, o_v_active = act_lines, o_h_total = last line_len, o_crc, o_err.
  - Pulse o_frame_valid; increment o_frame_cnt.
  - o_locked <= (err == 0).
  - Clear the per-frame counters and error accumulators.

Latency and ordering:
- o_frame_valid asserts on the 2nd rising edge after the edge that first samples vsync asserted. Outputs hold until the next frame close.
- hsync and vsync edges in the same cycle: the line close is applied first, so that line counts into the ending frame. That hsync edge then also begins line 0 of the new frame, with line_cnt reset to 0.
- A DE cycle that coincides with a vsync edge belongs to the new frame's CRC.
- Counters saturate and never wrap. A saturated line count yields a mismatch flag.

Decomposition:
- Package video_chk_pkg holds:
  - CRC16_INIT and CRC16_POLY
  - function crc16_step24(crc, data24)
  - typedef err_idx_e (ERR_HTOT, ERR_HACT, ERR_VTOT, ERR_VACT)
- One sub-module, video_chk_line_meter: S1 register, edge detection, h_cnt/de_cnt, line_len output and line-strobe output.
- The top handles the frame accumulators and the CRC.

Test Plan:
Bench uses H_ACTIVE=8, H_TOTAL=12, V_ACTIVE=4, V_TOTAL=6; DE on cycles 2..9 of lines 1..4.
- Clean stream, 3 frames -> 2 o_frame_valid pulses; o_h_total=12, o_v_total=6, o_v_active=4, o_err=0, o_locked=1, o_frame_cnt=2. o_crc matches the bench model.
- One line of 13 cycles in frame 2 -> that frame o_err=4'b0001, o_locked=0; the next clean frame restores o_locked=1.
- 7 DE cycles on one line -> o_err[1]=1 and o_v_active=4; o_crc differs from the clean frame.
- Frame with 7 lines and 5 DE lines -> o_err=4'b1100, o_v_total=7, o_v_active=5.
- hsync and vsync leading edges in the same cycle -> the ending frame reports o_v_total=6; the new frame counts 6 lines and reports no err[2].
- sys_rst_n low mid-frame 2 -> all outputs 0 immediately. The first vsync after release yields no pulse; the next frame reports o_frame_cnt=1.
